// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for alu_iterative.
// ALU_ITERATIVE_DIV_EN selects whether DIV/DIVU run on the iterative datapath.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_SRA   = 4'b1010;
    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;
    localparam logic [3:0] OP_PASSB = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: is_iterative = 1'b1;
`ifdef ALU_ITERATIVE_DIV_EN
            OP_DIV, OP_DIVU:   is_iterative = 1'b1;
`endif
            default:           is_iterative = 1'b0;
        endcase
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/alu_muldiv_core.sv
// Unsigned shift-add multiplier / restoring divider over magnitudes, one step per cycle.
// The divide step exists only when ALU_ITERATIVE_DIV_EN is defined.
module alu_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_md;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

`ifdef ALU_ITERATIVE_DIV_EN
    logic             r_is_div;
    logic [WIDTH:0]   w_div_trial;
`else
    logic             w_unused_div;
    assign w_unused_div = i_is_div;
`endif

    always_comb begin
        // {hi,lo} shifts right; lo starts as multiplier, ends as product low half
        w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_md} : {(WIDTH+1){1'b0}});
        w_hi_next = w_mul_sum[WIDTH:1];
        w_lo_next = {w_mul_sum[0], r_lo[WIDTH-1:1]};
`ifdef ALU_ITERATIVE_DIV_EN
        // {hi,lo} shifts left; a non-negative trial difference sets the quotient bit
        w_div_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_md};
        if (r_is_div) begin
            if (!w_div_trial[WIDTH]) begin
                w_hi_next = w_div_trial[WIDTH-1:0];
                w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_next = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
                w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_md  <= '0;
`ifdef ALU_ITERATIVE_DIV_EN
            r_is_div <= 1'b0;
`endif
        end else if (i_load) begin
            r_cnt <= CNT_W'(WIDTH - 1);
            r_hi  <= '0;
            r_lo  <= i_op_a;
            r_md  <= i_op_b;
`ifdef ALU_ITERATIVE_DIV_EN
            r_is_div <= i_is_div;
`endif
        end else if (i_step) begin
            r_hi <= w_hi_next;
            r_lo <= w_lo_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_last = (r_cnt == '0);
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle logic/shift ops plus iterative MULT/MULTU (and DIV/DIVU
// when ALU_ITERATIVE_DIV_EN is defined) behind a Start/Busy/Done handshake.
//   state   | meaning
//   ST_IDLE | waiting for Start; single-cycle ops complete here
//   ST_RUN  | one multiply/divide step per cycle
//   ST_FIX  | sign correction and result write-back
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] HiResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int MSB     = WIDTH - 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_alu_result;
    logic [WIDTH-1:0] r_hi_result;
    logic             r_overflow;
    logic             r_done;
    logic             r_neg_lo;
`ifdef ALU_ITERATIVE_DIV_EN
    logic             r_is_div;
    logic             r_neg_hi;
    logic             r_div0;
`endif

    logic             w_load;
    logic             w_iter;
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_core_last;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_ovf;
    logic [2*WIDTH-1:0] w_prod_raw;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_fix_lo;
    logic [WIDTH-1:0] w_fix_hi;

    always_comb begin
        w_iter   = is_iterative(ALUControl);
        w_load   = Start && (r_state == ST_IDLE) && w_iter;
        w_is_div = (ALUControl == OP_DIV) || (ALUControl == OP_DIVU);
        w_a_neg  = is_signed_op(ALUControl) && A[MSB];
        w_b_neg  = is_signed_op(ALUControl) && B[MSB];
        w_a_mag  = w_a_neg ? -A : A;
        w_b_mag  = w_b_neg ? -B : B;
    end

    always_comb begin
        w_shamt     = A[SHAMT_W-1:0];
        w_sum       = A + B;
        w_diff      = A - B;
        w_sc_result = '0;
        w_sc_ovf    = 1'b0;
        case (ALUControl)
            OP_AND:   w_sc_result = A & B;
            OP_OR:    w_sc_result = A | B;
            OP_ADD: begin
                w_sc_result = w_sum;
                w_sc_ovf    = (A[MSB] == B[MSB]) && (w_sum[MSB] != A[MSB]);
            end
            OP_XOR:   w_sc_result = A ^ B;
            OP_NOR:   w_sc_result = ~(A | B);
            OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ovf    = (A[MSB] != B[MSB]) && (w_diff[MSB] != A[MSB]);
            end
            OP_SLT:   w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU:  w_sc_result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:   w_sc_result = B << w_shamt;
            OP_SRL:   w_sc_result = B >> w_shamt;
            OP_SRA:   w_sc_result = WIDTH'($signed(B) >>> w_shamt);
            OP_PASSB: w_sc_result = B;
            default:  w_sc_result = '0;
        endcase
    end

    always_comb begin
        w_prod_raw = {w_core_hi, w_core_lo};
        w_prod     = r_neg_lo ? -w_prod_raw : w_prod_raw;
        w_fix_lo   = w_prod[WIDTH-1:0];
        w_fix_hi   = w_prod[2*WIDTH-1:WIDTH];
`ifdef ALU_ITERATIVE_DIV_EN
        // divide-by-zero forces an all-ones quotient; remainder already equals |A|
        if (r_is_div) begin
            w_fix_lo = r_div0 ? {WIDTH{1'b1}} : (r_neg_lo ? -w_core_lo : w_core_lo);
            w_fix_hi = r_neg_hi ? -w_core_hi : w_core_hi;
        end
`endif
    end

    alu_muldiv_core #(
        .WIDTH(WIDTH)
    ) u_muldiv_core (
        .i_clk    (Clk),
        .i_reset  (Reset),
        .i_load   (w_load),
        .i_step   (r_state == ST_RUN),
        .i_is_div (w_is_div),
        .i_op_a   (w_a_mag),
        .i_op_b   (w_b_mag),
        .o_last   (w_core_last),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_alu_result <= '0;
            r_hi_result  <= '0;
            r_overflow   <= 1'b0;
            r_done       <= 1'b0;
            r_neg_lo     <= 1'b0;
`ifdef ALU_ITERATIVE_DIV_EN
            r_is_div     <= 1'b0;
            r_neg_hi     <= 1'b0;
            r_div0       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        if (w_iter) begin
                            r_state  <= ST_RUN;
                            r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef ALU_ITERATIVE_DIV_EN
                            r_is_div <= w_is_div;
                            r_neg_hi <= w_a_neg;
                            r_div0   <= (B == '0);
`endif
                        end else begin
                            r_alu_result <= w_sc_result;
                            r_hi_result  <= '0;
                            r_overflow   <= w_sc_ovf;
                            r_done       <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_core_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_alu_result <= w_fix_lo;
                    r_hi_result  <= w_fix_hi;
                    r_overflow   <= 1'b0;
                    r_done       <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ALUResult = r_alu_result;
    assign HiResult  = r_hi_result;
    assign Zero      = (r_alu_result == '0);
    assign Overflow  = r_overflow;
    assign Busy      = (r_state != ST_IDLE);
    assign Done      = r_done;

endmodule
